uac_reg_file: RTL and testbench

//   Control register file fed by the write-only I2C slave (addr/data/write_req).

---
 rtl/uac_reg_pkg.sv | 28 ++
 rtl/uac_reg_file_vol_ramp.sv | 29 ++
 rtl/uac_reg_file.sv | 114 +++++++++++
 tb/tb_uac_reg_file.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/uac_reg_pkg.sv
// uac_reg_pkg: shared constants and types for the UAC control register file.
//   Register map addresses, CTRL bit positions, mute attenuation value,
//   field widths and the configuration bundle that moves shadow -> active.
package uac_reg_pkg;
  localparam int A_CTRL  = 0;
  localparam int A_VOL_L = 1;
  localparam int A_VOL_R = 2;
  localparam int A_FMT   = 3;
  localparam int A_FILT  = 4;
  localparam int A_GPIO  = 5;

  localparam int CTRL_COMMIT = 0;
  localparam int CTRL_MUTE   = 1;

  localparam int VOL_W  = 8;
  localparam int NUM_CH = 2;
  localparam int FMT_W  = 3;
  localparam int FILT_W = 3;

  localparam logic [VOL_W-1:0] VOL_MUTE = 8'hFF;

  // Everything that is staged in shadows and applied atomically on commit.
  typedef struct packed {
    logic [FILT_W-1:0]             filt;
    logic [FMT_W-1:0]              fmt;
    logic [NUM_CH-1:0][VOL_W-1:0]  vol;
  } cfg_t;
endpackage

// File: rtl/uac_reg_file_vol_ramp.sv
// vol_ramp: one attenuation channel. On each step strobe the current value
//   moves 1 LSB toward target; it holds once equal, so it can never overshoot
//   or wrap past 0x00/0xFF.
//   clk, rst      clock, synchronous active-high reset (cur <= VOL_RST)
//   target        attenuation to approach
//   step          one-cycle step strobe from the shared prescaler
//   cur           current attenuation
//   at_target     cur == target
module vol_ramp
  import uac_reg_pkg::*;
#(
  parameter logic [VOL_W-1:0] VOL_RST = 8'hFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [VOL_W-1:0] target,
  input  logic             step,
  output logic [VOL_W-1:0] cur,
  output logic             at_target
);
  assign at_target = (cur == target);

  always_ff @(posedge clk) begin
    if (rst)
      cur <= VOL_RST;
    else if (step && !at_target)
      cur <= (cur < target) ? cur + 8'd1 : cur - 8'd1;
  end
endmodule

// File: rtl/uac_reg_file.sv
// uac_reg_file: control register file written by the I2C slave.
//   Shadow registers for volume/format/filter are applied together on a
//   commit write; attenuation then ramps toward the committed (or mute)
//   target one LSB every RAMP_DIV clocks.
//   clk, rst          clock, synchronous active-high reset
//   addr/data         register address and write data, valid with write_req
//   write_req         one-cycle write strobe
//   vol_l, vol_r      current attenuation per channel
//   fmt, filt         active format / DAC filter
//   gpio              direct output byte
//   ramping           registered: some channel was off target last cycle
//   cfg_update        one-cycle pulse when a commit is applied
module uac_reg_file
  import uac_reg_pkg::*;
#(
  parameter int               REG_ADDR_WIDTH = 3,
  parameter int               RAMP_DIV       = 256,
  parameter logic [VOL_W-1:0] VOL_RST        = 8'hFF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] addr,
  input  logic [7:0]                data,
  input  logic                      write_req,
  output logic [VOL_W-1:0]          vol_l,
  output logic [VOL_W-1:0]          vol_r,
  output logic [FMT_W-1:0]          fmt,
  output logic [FILT_W-1:0]         filt,
  output logic [7:0]                gpio,
  output logic                      ramping,
  output logic                      cfg_update
);
  localparam int PW = (RAMP_DIV > 2) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(RAMP_DIV - 1);

  cfg_t shadow, active;
  logic mute;

  logic wr_ctrl, commit;
  assign wr_ctrl = write_req && (addr == REG_ADDR_WIDTH'(A_CTRL));
  assign commit  = wr_ctrl && data[CTRL_COMMIT];

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow     <= '0;
      active     <= '0;
      active.vol <= {NUM_CH{VOL_RST}};
      mute       <= 1'b0;
      gpio       <= '0;
      cfg_update <= 1'b0;
    end else begin
      cfg_update <= commit;
      if (write_req) begin
        case (addr)
          REG_ADDR_WIDTH'(A_CTRL): begin
            mute <= data[CTRL_MUTE];
            if (data[CTRL_COMMIT]) active <= shadow;
          end
          REG_ADDR_WIDTH'(A_VOL_L): shadow.vol[0] <= data;
          REG_ADDR_WIDTH'(A_VOL_R): shadow.vol[1] <= data;
          REG_ADDR_WIDTH'(A_FMT):   shadow.fmt    <= data[FMT_W-1:0];
          REG_ADDR_WIDTH'(A_FILT):  shadow.filt   <= data[FILT_W-1:0];
          REG_ADDR_WIDTH'(A_GPIO):  gpio          <= data;
          default: ; // reserved addresses: no side effect
        endcase
      end
    end
  end

  assign fmt  = active.fmt;
  assign filt = active.filt;

  // Per-channel targets and ramps
  logic [NUM_CH-1:0][VOL_W-1:0] tgt, cur;
  logic [NUM_CH-1:0]            at;
  logic                         diff, step;
  logic [PW-1:0]                pre;

  assign diff = ~&at;
  assign step = diff && (pre == PRE_MAX);

  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_ch
      assign tgt[i] = mute ? VOL_MUTE : active.vol[i];
      vol_ramp #(.VOL_RST(VOL_RST)) u_ramp (
        .clk       (clk),
        .rst       (rst),
        .target    (tgt[i]),
        .step      (step),
        .cur       (cur[i]),
        .at_target (at[i])
      );
    end
  endgenerate

  // Shared prescaler: free-runs only while a channel is off target, so the
  // first step lands RAMP_DIV clocks after a target change from idle. A new
  // target mid-ramp keeps the running count.
  always_ff @(posedge clk) begin
    if (rst || !diff || step)
      pre <= '0;
    else
      pre <= pre + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ramping <= 1'b0;
    else     ramping <= diff;
  end

  assign vol_l = cur[0];
  assign vol_r = cur[1];
endmodule

// File: tb/tb_uac_reg_file.sv
module tb_uac_reg_file;
  localparam int RD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] addr = '0;
  logic [7:0] data = '0;
  logic       write_req = 1'b0;
  logic [7:0] vol_l, vol_r, gpio;
  logic [2:0] fmt, filt;
  logic       ramping, cfg_update;

  always #5 clk = ~clk;

  uac_reg_file #(.REG_ADDR_WIDTH(3), .RAMP_DIV(RD), .VOL_RST(8'hFF)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .write_req(write_req),
    .vol_l(vol_l), .vol_r(vol_r), .fmt(fmt), .filt(filt), .gpio(gpio),
    .ramping(ramping), .cfg_update(cfg_update)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural reference: register map as arrays, volumes as integers that
  // move one step toward the target every RD clocks of off-target time.
  int m_sh[8];     // staged values by address (1..4 used)
  int m_com[2];    // committed volume
  int m_fmt, m_filt, m_gpio, m_mute, m_cfg, m_ramp, m_cnt;
  int m_v[2];
  int t[2];
  bit off;

  always @(posedge clk) begin
    if (rst) begin
      foreach (m_sh[k]) m_sh[k] = 0;
      m_com = '{255, 255}; m_v = '{255, 255};
      m_fmt = 0; m_filt = 0; m_gpio = 0; m_mute = 0; m_cfg = 0; m_ramp = 0; m_cnt = 0;
    end else begin
      for (int c = 0; c < 2; c++) t[c] = m_mute ? 255 : m_com[c];
      off = (m_v[0] != t[0]) || (m_v[1] != t[1]);
      if (!off) m_cnt = 0;
      else if (m_cnt == RD - 1) begin
        m_cnt = 0;
        for (int c = 0; c < 2; c++)
          if (m_v[c] < t[c]) m_v[c]++; else if (m_v[c] > t[c]) m_v[c]--;
      end else m_cnt++;
      m_ramp = off;
      m_cfg = 0;
      if (write_req) begin
        case (int'(addr))
          0: begin
            m_mute = int'(data[1]);
            if (data[0]) begin
              m_com[0] = m_sh[1]; m_com[1] = m_sh[2];
              m_fmt = m_sh[3]; m_filt = m_sh[4]; m_cfg = 1;
            end
          end
          1, 2: m_sh[addr] = int'(data);
          3, 4: m_sh[addr] = int'(data) % 8;
          5: m_gpio = int'(data);
          default: ;
        endcase
      end
    end
  end

  task automatic cyc(input logic r, input logic w, input int a, input int d);
    rst = r; write_req = w; addr = a[2:0]; data = d[7:0];
    @(posedge clk);
    @(negedge clk);
    chk("vol_l", vol_l, m_v[0]);
    chk("vol_r", vol_r, m_v[1]);
    chk("fmt", fmt, m_fmt);
    chk("filt", filt, m_filt);
    chk("gpio", gpio, m_gpio);
    chk("ramping", ramping, m_ramp);
    chk("cfg_update", cfg_update, m_cfg);
  endtask

  task automatic wr(input int a, input int d);
    cyc(1'b0, 1'b1, a, d);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    // 1: reset state
    cyc(1'b1, 1'b0, 0, 0);
    cyc(1'b1, 1'b0, 0, 0);
    idle(1);
    chk("rst_vol_l", vol_l, 8'hFF);
    chk("rst_vol_r", vol_r, 8'hFF);
    chk("rst_ramping", ramping, 0);

    // 2: stage and commit, left ramps FF -> F0
    wr(1, 8'hF0); wr(2, 8'hFF); wr(3, 5);
    chk("fmt_no_commit", fmt, 0);
    wr(0, 8'h01);
    chk("cfg_pulse", cfg_update, 1);
    chk("fmt_commit", fmt, 5);
    idle(1);
    chk("cfg_one_shot", cfg_update, 0);
    idle(15 * RD + 2);
    chk("vol_l_f0", vol_l, 8'hF0);
    chk("vol_r_ff", vol_r, 8'hFF);
    chk("ramp_done", ramping, 0);

    // 3: shadow write without commit changes nothing
    wr(1, 8'h10);
    idle(4 * RD);
    chk("no_commit_vol", vol_l, 8'hF0);

    // 4: soft mute and unmute
    wr(0, 8'h02);
    idle(15 * RD + 3);
    chk("muted", vol_l, 8'hFF);
    wr(0, 8'h00);
    idle(15 * RD + 3);
    chk("unmuted", vol_l, 8'hF0);

    // 5: reverse mid-ramp, then reset mid-ramp
    wr(1, 8'hF0); wr(0, 8'h02);
    idle(15 * RD + 3);
    wr(0, 8'h00);
    for (int k = 0; k < 100 && vol_l != 8'hF8; k++) idle(1);
    chk("reach_f8", vol_l, 8'hF8);
    wr(1, 8'hFC); wr(0, 8'h01);
    idle(10 * RD);
    chk("settle_fc", vol_l, 8'hFC);
    wr(1, 8'h00); wr(0, 8'h01);
    idle(5 * RD);
    chk("mid_ramp", ramping, 1);
    cyc(1'b1, 1'b0, 0, 0);
    chk("rst_abort", vol_l, 8'hFF);
    idle(2);

    // 6: gpio, reserved write, back-to-back writes
    wr(5, 8'hA5);
    chk("gpio_a5", gpio, 8'hA5);
    wr(6, 8'hFF);
    chk("reserved", gpio, 8'hA5);
    wr(3, 2); wr(4, 6); wr(5, 8'h3C); wr(0, 8'h01);
    chk("b2b_fmt", fmt, 2);
    chk("b2b_filt", filt, 6);
    chk("b2b_gpio", gpio, 8'h3C);

    // Random traffic against the model
    for (int k = 0; k < 4000; k++) begin
      int a, d;
      a = $urandom_range(0, 7);
      d = $urandom_range(0, 255);
      if (a == 0 && $urandom_range(0, 3) != 0) d = d & 8'h01;
      if (a == 1 || a == 2) d = (d & 8'h0F) | 8'hE0;
      cyc($urandom_range(0, 799) == 0, $urandom_range(0, 5) == 0, a, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
